mips_cpu_sequencer: RTL and testbench

//  Multicycle sequencer for the MIPS CPU datapath: steps each instruction through fetch, execute, memory,

---
 rtl/mips_cpu_pkg.sv | 28 ++
 rtl/mips_cpu_seq_perf.sv | 25 ++
 rtl/mips_cpu_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mips_cpu_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU control path.
// The state encodings are also what the sequencer drives on its debug state output.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_MDWAIT = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_t;

  // SPECIAL-opcode funct codes that route an instruction to the mult/div unit
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // Helper for the decoder side: true for MULT/MULTU/DIV/DIVU
  function automatic logic is_muldiv_op(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == 6'd0) && (funct >= FUNCT_MULT) && (funct <= FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mips_cpu_seq_perf.sv
// Performance counters for the sequencer: retired instructions and bus stall cycles.
// Only instantiated when MIPS_SEQ_PERF_EN is defined. Both counters wrap naturally.
module mips_cpu_seq_perf #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             retire,
  input  logic             stall,
  output logic [CNT_W-1:0] instr_retired,
  output logic [CNT_W-1:0] stall_cycles
);

  // Count one retirement per writeback cycle and one stall per waited bus cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_retired <= '0;
      stall_cycles  <= '0;
    end else begin
      if (retire) instr_retired <= instr_retired + CNT_W'(1);
      if (stall)  stall_cycles  <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_cpu_sequencer.sv
// Multicycle sequencer for the MIPS CPU datapath.
// Steps each instruction through FETCH, EXEC, MEM or MDWAIT, and WB, driving the
// shared memory port and the commit strobes. Strobes are decoded from the current
// state so an asynchronous reset drops any bus request in the same cycle.
// Optional feature: define MIPS_SEQ_PERF_EN to add instr_retired / stall_cycles counters.
module mips_cpu_sequencer
  import mips_cpu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 256
`ifdef MIPS_SEQ_PERF_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       waitrequest,
  input  logic       ctl_memread,
  input  logic       ctl_memwrite,
  input  logic       ctl_regwrite,
  input  logic       is_muldiv,
  input  logic       md_done,
  input  logic       pc_zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       md_start,
  output logic       active,
  output logic       bus_err,
  output logic [2:0] state
`ifdef MIPS_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_retired,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  seq_state_t  cur;
  logic [31:0] wait_cnt;
  logic        fetch_halt;
  logic        bus_req;
  logic        stall;
  logic        timeout;

  // The wait counter is zero only on the first cycle of FETCH, which is where a zero PC halts
  assign fetch_halt = (cur == ST_FETCH) && (wait_cnt == 32'd0) && pc_zero;
  assign bus_req    = ((cur == ST_FETCH) && !fetch_halt) || (cur == ST_MEM);
  assign stall      = bus_req && waitrequest;
  // Error once an access has already waited WAIT_LIMIT cycles and is still stalled
  assign timeout    = stall && (WAIT_LIMIT != 32'd0) && (wait_cnt == WAIT_LIMIT);

  // State sequencing, per-access wait counting and the sticky bus error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= ST_IDLE;
      wait_cnt <= 32'd0;
      bus_err  <= 1'b0;
    end else begin
      case (cur)
        ST_IDLE: begin
          cur      <= ST_FETCH;
          wait_cnt <= 32'd0;
        end
        ST_FETCH: begin
          if (fetch_halt) begin
            cur <= ST_HALT;
          end else if (timeout) begin
            bus_err <= 1'b1;
            cur     <= ST_HALT;
          end else if (waitrequest) begin
            wait_cnt <= wait_cnt + 32'd1;
          end else begin
            cur <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (ctl_memread || ctl_memwrite) begin
            cur      <= ST_MEM;
            wait_cnt <= 32'd0;
          end else if (is_muldiv) begin
            cur <= ST_MDWAIT;
          end else begin
            cur <= ST_WB;
          end
        end
        ST_MEM: begin
          if (timeout) begin
            bus_err <= 1'b1;
            cur     <= ST_HALT;
          end else if (waitrequest) begin
            wait_cnt <= wait_cnt + 32'd1;
          end else begin
            cur <= ST_WB;
          end
        end
        ST_MDWAIT: begin
          if (md_done) cur <= ST_WB;
        end
        ST_WB: begin
          cur      <= ST_FETCH;
          wait_cnt <= 32'd0;
        end
        ST_HALT: cur <= ST_HALT;
        default: cur <= ST_HALT;
      endcase
    end
  end

  // Decode the bus request and commit strobes from the current state
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    md_start  = 1'b0;
    active    = 1'b0;
    case (cur)
      ST_FETCH: begin
        active   = 1'b1;
        mem_read = !fetch_halt;
        ir_write = !fetch_halt && !waitrequest;
      end
      ST_EXEC: begin
        active   = 1'b1;
        md_start = !(ctl_memread || ctl_memwrite) && is_muldiv;
      end
      ST_MEM: begin
        active    = 1'b1;
        addr_sel  = 1'b1;
        mem_read  = ctl_memread;
        mem_write = ctl_memwrite && !ctl_memread;
      end
      ST_MDWAIT: begin
        active = 1'b1;
      end
      ST_WB: begin
        active    = 1'b1;
        pc_write  = 1'b1;
        reg_write = ctl_regwrite;
      end
      default: begin
        active = 1'b0;
      end
    endcase
  end

  assign state = cur;

`ifdef MIPS_SEQ_PERF_EN
  mips_cpu_seq_perf #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .retire       (cur == ST_WB),
    .stall        (stall),
    .instr_retired(instr_retired),
    .stall_cycles (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Self-checking bench for mips_cpu_sequencer.
// Each instruction is expanded into its expected cycle-by-cycle trace (state plus
// strobes, and the bus/mult-div inputs to drive) and then replayed against the DUT.
module tb_mips_cpu_sequencer;

  localparam int WL = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                         S_MDWAIT = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BOTH = 3, K_MULDIV = 4;

  logic       clk;
  logic       rst_n;
  logic       waitrequest, ctl_memread, ctl_memwrite, ctl_regwrite;
  logic       is_muldiv, md_done, pc_zero;
  logic       mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write;
  logic       md_start, active, bus_err;
  logic [2:0] state;
`ifdef MIPS_SEQ_PERF_EN
  logic [31:0] instr_retired, stall_cycles;
`endif

  mips_cpu_sequencer #(
    .WAIT_LIMIT(WL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .waitrequest (waitrequest),
    .ctl_memread (ctl_memread),
    .ctl_memwrite(ctl_memwrite),
    .ctl_regwrite(ctl_regwrite),
    .is_muldiv   (is_muldiv),
    .md_done     (md_done),
    .pc_zero     (pc_zero),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .addr_sel    (addr_sel),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .md_start    (md_start),
    .active      (active),
    .bus_err     (bus_err),
    .state       (state)
`ifdef MIPS_SEQ_PERF_EN
    ,
    .instr_retired(instr_retired),
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle: outs = {mem_read,mem_write,addr_sel,ir_write,pc_write,reg_write,md_start,active,bus_err}
  typedef struct {
    logic [2:0] st;
    logic [8:0] outs;
    logic wr, mdd, cmr, cmw, crw, cmd;
  } step_t;

  step_t q[$];
  int checks = 0, passes = 0, fails = 0;
  int exp_ret = 0, exp_stall = 0;

  function automatic logic [8:0] ov(input logic mr, mw, as_, irw, pcw, rw, mds, act);
    return {mr, mw, as_, irw, pcw, rw, mds, act, 1'b0};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [8:0] obs_outs();
    return {mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write, md_start, active, bus_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input step_t s);
    chk("state", 32'(state), 32'(s.st));
    chk("strobes", 32'(obs_outs()), 32'(s.outs));
`ifdef MIPS_SEQ_PERF_EN
    chk("instr_retired", instr_retired, 32'(exp_ret));
    chk("stall_cycles", stall_cycles, 32'(exp_stall));
`endif
  endtask

  // Expected trace of the single IDLE cycle after reset release
  task automatic planIdle();
    step_t s;
    s.st = S_IDLE; s.outs = '0; s.wr = rb(); s.mdd = rb();
    s.cmr = rb(); s.cmw = rb(); s.crw = rb(); s.cmd = rb();
    q.push_back(s);
  endtask

  // Expected trace of one instruction: f fetch stalls, m memory stalls, lat mult/div latency
  task automatic planInstr(input int kind, input logic regw, input int f, input int m, input int lat);
    step_t s;
    logic  mem;
    s.cmr = (kind == K_LOAD) || (kind == K_BOTH);
    s.cmw = (kind == K_STORE) || (kind == K_BOTH);
    s.crw = regw;
    s.cmd = (kind == K_MULDIV);
    mem   = s.cmr || s.cmw;
    for (int i = 0; i < f; i++) begin
      s.st = S_FETCH; s.outs = ov(1, 0, 0, 0, 0, 0, 0, 1); s.wr = 1'b1; s.mdd = rb();
      q.push_back(s);
    end
    s.st = S_FETCH; s.outs = ov(1, 0, 0, 1, 0, 0, 0, 1); s.wr = 1'b0; s.mdd = rb();
    q.push_back(s);
    s.st = S_EXEC; s.outs = ov(0, 0, 0, 0, 0, 0, s.cmd, 1); s.wr = rb(); s.mdd = rb();
    q.push_back(s);
    if (mem) begin
      for (int i = 0; i <= m; i++) begin
        s.st = S_MEM; s.outs = ov(s.cmr, s.cmw && !s.cmr, 1, 0, 0, 0, 0, 1);
        s.wr = (i < m); s.mdd = rb();
        q.push_back(s);
      end
    end else if (s.cmd) begin
      for (int i = 0; i < lat; i++) begin
        s.st = S_MDWAIT; s.outs = ov(0, 0, 0, 0, 0, 0, 0, 1); s.wr = rb(); s.mdd = (i == lat - 1);
        q.push_back(s);
      end
    end
    s.st = S_WB; s.outs = ov(0, 0, 0, 0, 1, regw, 0, 1); s.wr = rb(); s.mdd = rb();
    q.push_back(s);
  endtask

  // Replay n queued cycles (all of them when n < 0), checking each one mid low phase
  task automatic applyStimulus(input int n);
    step_t s;
    int    done = 0;
    while (q.size() > 0 && (n < 0 || done < n)) begin
      s = q.pop_front();
      @(negedge clk);
      waitrequest  = s.wr;
      md_done      = s.mdd;
      ctl_memread  = s.cmr;
      ctl_memwrite = s.cmw;
      ctl_regwrite = s.crw;
      is_muldiv    = s.cmd;
      pc_zero      = 1'b0;
      #1;
      checkOutput(s);
      if (s.st == S_WB) exp_ret++;
      if ((s.st == S_FETCH || s.st == S_MEM) && s.wr && (s.outs[8] || s.outs[7])) exp_stall++;
      done++;
    end
  endtask

  // Assert reset with random inputs, check the idle outputs, release after a rising edge
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    waitrequest = rb(); md_done = rb(); ctl_memread = rb(); ctl_memwrite = rb();
    ctl_regwrite = rb(); is_muldiv = rb(); pc_zero = rb();
    #1;
    chk("reset_state", 32'(state), 32'(S_IDLE));
    chk("reset_strobes", 32'(obs_outs()), 32'd0);
    exp_ret = 0; exp_stall = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    pc_zero = 1'b0;
  endtask

  initial begin
    int fcyc;
    logic held;
    rst_n = 1'b0;
    {waitrequest, md_done, ctl_memread, ctl_memwrite, ctl_regwrite, is_muldiv, pc_zero} = '0;

    // ADDU with no stalls, followed by the directed load/store/priority/divide cases
    doReset();
    planIdle();
    planInstr(K_ALU, 1'b1, 0, 0, 0);
    planInstr(K_LOAD, 1'b1, 2, 3, 0);
    planInstr(K_STORE, 1'b0, 0, 1, 0);
    planInstr(K_BOTH, 1'b1, 0, 0, 0);
    planInstr(K_MULDIV, 1'b0, 0, 0, 5);
    planInstr(K_LOAD, 1'b1, WL, WL, 0);
    applyStimulus(-1);

    // Random instruction mix, stalls up to the allowed limit
    for (int i = 0; i < 40; i++)
      planInstr($urandom_range(0, 4), rb(), $urandom_range(0, WL), $urandom_range(0, WL),
                $urandom_range(1, 6));
    applyStimulus(-1);

    // Reset in the middle of a stalled load: request drops at once, then IDLE then FETCH
    doReset();
    planIdle();
    planInstr(K_LOAD, 1'b1, 0, 3, 0);
    applyStimulus(5);
    q.delete();
    @(negedge clk);
    waitrequest = 1'b1;
    #1 chk("mem_stall_read", 32'(mem_read), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_mem_read", 32'(mem_read), 32'd0);
    chk("async_state", 32'(state), 32'(S_IDLE));
    chk("async_strobes", 32'(obs_outs()), 32'd0);
    exp_ret = 0; exp_stall = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    planIdle();
    planInstr(K_ALU, 1'b1, 0, 0, 0);
    applyStimulus(-1);

    // Zero PC at fetch: no bus request, then HALT forever
    doReset();
    planIdle();
    applyStimulus(-1);
    @(negedge clk);
    pc_zero = 1'b1; waitrequest = rb();
    #1;
    chk("pc_zero_state", 32'(state), 32'(S_FETCH));
    chk("pc_zero_mem_read", 32'(mem_read), 32'd0);
    chk("pc_zero_ir_write", 32'(ir_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc_zero = rb(); waitrequest = rb(); md_done = rb(); ctl_memread = rb(); ctl_regwrite = rb();
      #1;
      chk("halt_state", 32'(state), 32'(S_HALT));
      chk("halt_strobes", 32'(obs_outs()), 32'd0);
    end

    // Stuck waitrequest: WL stalls tolerated, the next stalled cycle raises bus_err and halts
    doReset();
    planIdle();
    applyStimulus(-1);
    fcyc = 0;
    held = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      waitrequest = 1'b1;
      #1;
      if (state == S_HALT) break;
      fcyc++;
      if (mem_read !== 1'b1) held = 1'b0;
    end
    chk("stuck_fetch_cycles", 32'(fcyc), 32'(WL + 1));
    chk("stuck_read_held", 32'(held), 32'd1);
    chk("stuck_state", 32'(state), 32'(S_HALT));
    chk("stuck_bus_err", 32'(bus_err), 32'd1);
    chk("stuck_mem_read", 32'(mem_read), 32'd0);
    chk("stuck_active", 32'(active), 32'd0);
    doReset();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
